// File: rtl/alu_multiply_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_multiply_sequencer_pkg
// Shared definitions for the multiply sequencer: the ALU function-select
// codes it issues and the controller state encoding.
// ---------------------------------------------------------------------------
package alu_multiply_sequencer_pkg;

    // ALU function-select codes used by the sequencer
    localparam logic [4:0] FS_PASS16 = 5'h10;  // idle drive, result unused
    localparam logic [4:0] FS_ADD16  = 5'h14;  // A + B
    localparam logic [4:0] FS_LSL16  = 5'h1b;  // A << 1
    localparam logic [4:0] FS_LSR8   = 5'h0c;  // {8'h0, A[7:0] >> 1}

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADD    = 3'd1,
        ST_SHL    = 3'd2,
        ST_SHR    = 3'd3,
        ST_FINISH = 3'd4
    } mul_state_e;

endpackage : alu_multiply_sequencer_pkg

// File: rtl/alu_multiply_sequencer.sv
// ---------------------------------------------------------------------------
// alu_multiply_sequencer
// Unsigned shift-and-add multiplier controller. It does no arithmetic of its
// own: every add and shift is performed by the shared 16-bit ALU, which this
// block drives through ALU_A/ALU_B/ALU_FunSel while Busy is high, reading the
// result back on ALUOut.
//
// Ports
//   Clock       rising-edge clock
//   Reset       synchronous, active-high reset (aborts any operation)
//   Start       request, sampled only while idle
//   OpA, OpB    multiplicand / multiplier (OPERAND_WIDTH bits, legal 1..8)
//   ALUOut      combinational ALU result
//   ALU_A/B     ALU operands
//   ALU_FunSel  ALU function select
//   ALU_WF      ALU flag write enable, tied low so ALU flags are untouched
//   Busy        high in every non-idle state
//   Done        one-cycle pulse, coincident with the new Product
//   Product     16-bit result, held until the next completion
// ---------------------------------------------------------------------------
module alu_multiply_sequencer
    import alu_multiply_sequencer_pkg::*;
#(
    parameter int OPERAND_WIDTH = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic [OPERAND_WIDTH-1:0] OpA,
    input  logic [OPERAND_WIDTH-1:0] OpB,
    input  logic [15:0]              ALUOut,
    output logic [15:0]              ALU_A,
    output logic [15:0]              ALU_B,
    output logic [4:0]               ALU_FunSel,
    output logic                     ALU_WF,
    output logic                     Busy,
    output logic                     Done,
    output logic [15:0]              Product
);

    localparam int                CNT_W    = $clog2(OPERAND_WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OPERAND_WIDTH - 1);

    mul_state_e       state, state_nxt;
    logic [15:0]      m;    // shifted multiplicand
    logic [7:0]       q;    // remaining multiplier bits
    logic [15:0]      p;    // partial product
    logic [CNT_W-1:0] cnt;  // completed iterations

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge Clock) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: each combinational block assigns a default first, so no path
    // leaves an output unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (Start) state_nxt = OpB[0] ? ST_ADD : ST_SHL;
            ST_ADD:    state_nxt = ST_SHL;
            ST_SHL:    state_nxt = ST_SHR;
            // ALUOut[0] is the multiplier bit for the next iteration.
            ST_SHR:    if (cnt == CNT_LAST) state_nxt = ST_FINISH;
                       else                 state_nxt = ALUOut[0] ? ST_ADD : ST_SHL;
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: ALU drive and status, decoded from state only
    // -----------------------------------------------------------------------
    always_comb begin
        ALU_A      = 16'h0000;
        ALU_B      = 16'h0000;
        ALU_FunSel = FS_PASS16;
        case (state)
            ST_ADD: begin
                ALU_A      = p;
                ALU_B      = m;
                ALU_FunSel = FS_ADD16;
            end
            ST_SHL: begin
                ALU_A      = m;
                ALU_FunSel = FS_LSL16;
            end
            ST_SHR: begin
                ALU_A      = {8'h00, q};
                ALU_FunSel = FS_LSR8;
            end
            default: ;
        endcase
    end

    assign ALU_WF = 1'b0;
    assign Busy   = (state != ST_IDLE);
    assign Done   = (state == ST_FINISH);

    // -----------------------------------------------------------------------
    // Datapath registers: each captures the ALU result of its own step
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            m       <= '0;
            q       <= '0;
            p       <= '0;
            cnt     <= '0;
            Product <= '0;
        end else begin
            case (state)
                ST_IDLE: if (Start) begin
                    m   <= 16'(OpA);
                    q   <= 8'(OpB);
                    p   <= '0;
                    cnt <= '0;
                end
                ST_ADD: p <= ALUOut;
                ST_SHL: m <= ALUOut;
                ST_SHR: begin
                    q   <= ALUOut[7:0];
                    cnt <= cnt + CNT_W'(1);
                    // Load on the edge entering FINISH so Product and Done
                    // become visible in the same cycle.
                    if (cnt == CNT_LAST) Product <= p;
                end
                default: ;
            endcase
        end
    end

endmodule : alu_multiply_sequencer

// File: tb/tb_alu_multiply_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_multiply_sequencer
// Two sequencers (OPERAND_WIDTH 8 and 4), each paired with a behavioural ALU.
// Expected product, latency and FunSel trace are derived from the operands.
// ---------------------------------------------------------------------------
module tb_alu_multiply_sequencer;
    import alu_multiply_sequencer_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;

    // width-8 instance
    logic        start8 = 1'b0;
    logic [7:0]  opa8 = '0, opb8 = '0;
    logic [15:0] alu_out8, alu_a8, alu_b8, product8;
    logic [4:0]  fs8;
    logic        wf8, busy8, done8;
    logic [3:0]  flags8 = 4'b0101;

    // width-4 instance
    logic        start4 = 1'b0;
    logic [3:0]  opa4 = '0, opb4 = '0;
    logic [15:0] alu_out4, alu_a4, alu_b4, product4;
    logic [4:0]  fs4;
    logic        wf4, busy4, done4;
    logic [3:0]  flags4 = 4'b0101;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 Clock = ~Clock;

    alu_multiply_sequencer #(.OPERAND_WIDTH(8)) dut8 (
        .Clock(Clock), .Reset(Reset), .Start(start8), .OpA(opa8), .OpB(opb8),
        .ALUOut(alu_out8), .ALU_A(alu_a8), .ALU_B(alu_b8), .ALU_FunSel(fs8),
        .ALU_WF(wf8), .Busy(busy8), .Done(done8), .Product(product8)
    );

    alu_multiply_sequencer #(.OPERAND_WIDTH(4)) dut4 (
        .Clock(Clock), .Reset(Reset), .Start(start4), .OpA(opa4), .OpB(opb4),
        .ALUOut(alu_out4), .ALU_A(alu_a4), .ALU_B(alu_b4), .ALU_FunSel(fs4),
        .ALU_WF(wf4), .Busy(busy4), .Done(done4), .Product(product4)
    );

    // Behavioural stand-in for the shared ALU
    function automatic logic [15:0] alu_f(input logic [4:0] fs, input logic [15:0] a,
                                          input logic [15:0] b);
        case (fs)
            FS_ADD16: return a + b;
            FS_LSL16: return a << 1;
            FS_LSR8:  return {8'h00, a[7:0] >> 1};
            FS_PASS16: return a;
            default:  return 16'h0000;
        endcase
    endfunction

    assign alu_out8 = alu_f(fs8, alu_a8, alu_b8);
    assign alu_out4 = alu_f(fs4, alu_a4, alu_b4);

    always @(posedge Clock) begin
        if (wf8) flags8 <= {alu_out8 == 16'h0, alu_out8[15], 2'b10};
        if (wf4) flags4 <= {alu_out4 == 16'h0, alu_out4[15], 2'b10};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One multiplication on the selected instance. With spam set, Start is
    // held high with operands 9x9 for the whole operation, including FINISH.
    task automatic run_mul(input bit use4, input logic [7:0] a_in,
                           input logic [7:0] b_in, input bit spam);
        logic [7:0]  a, b;
        logic [15:0] exp_p;
        logic [4:0]  exp_fs[$];
        int w, lat, cyc, done_cyc, busy_cyc, seq_err, wf_err;

        w = use4 ? 4 : 8;
        a = use4 ? (a_in & 8'h0f) : a_in;
        b = use4 ? (b_in & 8'h0f) : b_in;
        exp_p = 16'(a) * 16'(b);
        for (int i = 0; i < w; i++) begin
            if (b[i]) exp_fs.push_back(FS_ADD16);
            exp_fs.push_back(FS_LSL16);
            exp_fs.push_back(FS_LSR8);
        end
        exp_fs.push_back(FS_PASS16);
        lat = exp_fs.size();

        @(negedge Clock);
        check("idle_busy", use4 ? busy4 : busy8, 1'b0);
        check("idle_done", use4 ? done4 : done8, 1'b0);
        if (use4) begin start4 = 1'b1; opa4 = a[3:0]; opb4 = b[3:0]; end
        else      begin start8 = 1'b1; opa8 = a;      opb8 = b;      end

        @(negedge Clock);
        cyc = 1; done_cyc = 0; busy_cyc = 0; seq_err = 0; wf_err = 0;
        while (cyc <= 100) begin
            if (spam) begin
                start8 = ~use4; start4 = use4;
                opa8 = 8'd9; opb8 = 8'd9; opa4 = 4'd9; opb4 = 4'd9;
            end else begin
                start8 = 1'b0; start4 = 1'b0;
                opa8 = 8'($urandom); opb8 = 8'($urandom);
                opa4 = 4'($urandom); opb4 = 4'($urandom);
            end
            if (use4 ? busy4 : busy8) busy_cyc++;
            if (cyc <= lat && (use4 ? fs4 : fs8) !== exp_fs[cyc-1]) seq_err++;
            if (use4 ? wf4 : wf8) wf_err++;
            if (use4 ? done4 : done8) begin
                done_cyc = cyc;
                break;
            end
            @(negedge Clock);
            cyc++;
        end
        if (!spam) begin start8 = 1'b0; start4 = 1'b0; end

        check("done_latency", done_cyc, lat);
        check("busy_cycles",  busy_cyc, lat);
        check("product",      use4 ? product4 : product8, exp_p);
        check("funsel_seq",   seq_err, 0);
        check("alu_wf_low",   wf_err, 0);
    endtask

    int dpulse;

    initial begin
        // Reset state
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        check("rst_busy",    busy8, 1'b0);
        check("rst_done",    done8, 1'b0);
        check("rst_product", product8, 16'h0);
        check("rst_funsel",  fs8, FS_PASS16);
        check("rst_alu_a",   alu_a8, 16'h0);

        // Directed cases
        run_mul(1'b0, 8'd5,   8'd3,   1'b0);   // 15, 19 cycles
        run_mul(1'b0, 8'd255, 8'd255, 1'b0);   // FE01, 25 cycles
        run_mul(1'b0, 8'd200, 8'd0,   1'b0);   // 0, 17 cycles, no ADD
        run_mul(1'b0, 8'd5,   8'd3,   1'b1);   // Start spam ignored -> 15
        run_mul(1'b0, 8'd9,   8'd9,   1'b0);   // accepted right after Done -> 81

        // Reset in cycle 6 of 7x7: abort, no Done
        @(negedge Clock);
        start8 = 1'b1; opa8 = 8'd7; opb8 = 8'd7;
        @(negedge Clock);
        start8 = 1'b0;
        repeat (5) @(negedge Clock);
        check("mid_busy_before", busy8, 1'b1);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check("abort_busy",    busy8, 1'b0);
        check("abort_done",    done8, 1'b0);
        check("abort_product", product8, 16'h0);
        dpulse = 0;
        repeat (30) begin
            @(negedge Clock);
            if (done8 || busy8) dpulse++;
        end
        check("abort_no_done", dpulse, 0);
        run_mul(1'b0, 8'd7, 8'd7, 1'b0);       // 49

        // Width-4 build
        run_mul(1'b1, 8'd15, 8'd15, 1'b0);     // 225, 13 cycles
        check("w8_idle_during_w4", busy8, 1'b0);

        // Random operands on both builds
        for (int i = 0; i < 16; i++) run_mul(1'b0, 8'($urandom), 8'($urandom), 1'b0);
        for (int i = 0; i < 6; i++)  run_mul(1'b1, 8'($urandom), 8'($urandom), 1'b0);
        run_mul(1'b0, 8'd1, 8'd128, 1'b0);     // single top multiplier bit
        run_mul(1'b1, 8'd0, 8'd8,   1'b0);

        // Product holds while idle
        repeat (3) @(negedge Clock);
        check("product_hold", product4, 16'h0);
        check("flags8_untouched", flags8, 4'b0101);
        check("flags4_untouched", flags4, 4'b0101);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule : tb_alu_multiply_sequencer
